// File: rtl/game_pkg.sv
// Shared types and defaults for the memorization-game round controller.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW   = 3'd1,
    ENTRY  = 3'd2,
    CHECK  = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_e;

  localparam int DIGIT_W              = 4;
  localparam int CNT_W                = 8;
  localparam int DEFAULT_SHOW_TICKS   = 6;
  localparam int DEFAULT_RESULT_TICKS = 4;
  localparam int DEFAULT_NUM_DIGITS   = 4;
  localparam int DEFAULT_MAX_LIVES    = 3;

endpackage

// File: rtl/game_sequencer_tick_counter.sv
// Counts tick pulses while enabled; done fires on the tick that reaches target.
module tick_counter
  import game_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // clr wins over a coincident tick, so the entry-edge tick is never counted
  always_comb begin
    cnt_d = cnt_q;
    if (clr)             cnt_d = '0;
    else if (en && tick) cnt_d = cnt_q + ONE;
  end

  assign done = en && tick && ((cnt_q + ONE) == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Round controller: start, show random value, collect digits, check, show result.
module game_sequencer
  import game_pkg::*;
#(
  parameter int SHOW_TICKS   = DEFAULT_SHOW_TICKS,
  parameter int RESULT_TICKS = DEFAULT_RESULT_TICKS,
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int MAX_LIVES    = DEFAULT_MAX_LIVES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic                          btnStart,
  input  logic                          btnEnter,
  input  logic [DIGIT_W-1:0]            digitIn,
  input  logic                          correct,
  output logic                          newRound,
  output logic                          displayPhase,
  output logic [DIGIT_W*NUM_DIGITS-1:0] userInt,
  output logic                          inputReady,
  output logic [1:0]                    digitIdx,
  output logic [7:0]                    score,
  output logic [1:0]                    lives,
  output logic                          gameOver
);

  localparam int UW = DIGIT_W * NUM_DIGITS;
  localparam logic [1:0] LAST_IDX   = 2'(NUM_DIGITS - 1);
  localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);

  state_e          state_q, state_d;
  logic [UW-1:0]   user_q, user_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      score_q, score_d;
  logic [1:0]      lives_q, lives_d;
  logic            new_round_q, new_round_d;
  logic            tick_done;
  logic            tick_clr;
  logic            tick_en;
  logic [CNT_W-1:0] tick_target;

  assign tick_en     = (state_q == SHOW) || (state_q == RESULT);
  assign tick_target = (state_q == RESULT) ? CNT_W'(RESULT_TICKS) : CNT_W'(SHOW_TICKS);
  assign tick_clr    = (state_d != state_q);

  tick_counter u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (tick_clr),
    .en     (tick_en),
    .tick   (tick),
    .target (tick_target),
    .done   (tick_done)
  );

  always_comb begin
    state_d     = state_q;
    user_d      = user_q;
    idx_d       = idx_q;
    score_d     = score_q;
    lives_d     = lives_q;
    new_round_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (btnStart) begin
          state_d     = SHOW;
          score_d     = '0;
          lives_d     = LIVES_INIT;
          new_round_d = 1'b1;
        end
      end
      SHOW: begin
        if (tick_done) begin
          state_d = ENTRY;
          user_d  = '0;
          idx_d   = '0;
        end
      end
      ENTRY: begin
        if (btnEnter) begin
          user_d = {user_q[UW-DIGIT_W-1:0], digitIn};
          idx_d  = idx_q + 2'd1;
          if (idx_q == LAST_IDX) state_d = CHECK;
        end
      end
      CHECK: begin
        if (correct) score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
        else         lives_d = lives_q - 2'd1;
        state_d = RESULT;
      end
      RESULT: begin
        if (tick_done) begin
          if (lives_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d     = SHOW;
            new_round_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      user_q      <= '0;
      idx_q       <= '0;
      score_q     <= '0;
      lives_q     <= LIVES_INIT;
      new_round_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      user_q      <= user_d;
      idx_q       <= idx_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      new_round_q <= new_round_d;
    end
  end

  assign newRound     = new_round_q;
  assign displayPhase = (state_q == SHOW);
  assign inputReady   = (state_q == RESULT);
  assign gameOver     = (state_q == OVER);
  assign userInt      = user_q;
  assign digitIdx     = idx_q;
  assign score        = score_q;
  assign lives        = lives_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench with an abstract game model checked every falling clock edge.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        btnStart = 1'b0;
  logic        btnEnter = 1'b0;
  logic        correct = 1'b0;
  logic [3:0]  digitIn = 4'h0;
  logic        newRound, displayPhase, inputReady, gameOver;
  logic [15:0] userInt;
  logic [1:0]  digitIdx, lives;
  logic [7:0]  score;

  game_sequencer dut (
    .clk(clk), .rst(rst), .tick(tick), .btnStart(btnStart), .btnEnter(btnEnter),
    .digitIn(digitIn), .correct(correct), .newRound(newRound),
    .displayPhase(displayPhase), .userInt(userInt), .inputReady(inputReady),
    .digitIdx(digitIdx), .score(score), .lives(lives), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 show, 2 entry, 3 check, 4 result, 5 over;
  // m_left is ticks still needed before leaving a timed phase.
  int          m_mode = 0, m_left = 0, m_digits = 0, m_score = 0, m_lives = 3;
  logic [15:0] m_user = 16'h0;
  bit          m_nr = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= 0; m_left <= 0; m_digits <= 0; m_score <= 0;
      m_lives <= 3; m_user <= 16'h0; m_nr <= 1'b0;
    end else begin
      m_nr <= 1'b0;
      case (m_mode)
        0, 5: if (btnStart) begin
          m_mode <= 1; m_left <= 6; m_score <= 0; m_lives <= 3; m_nr <= 1'b1;
        end
        1: if (tick) begin
          if (m_left == 1) begin m_mode <= 2; m_user <= 16'h0; m_digits <= 0; end
          else m_left <= m_left - 1;
        end
        2: if (btnEnter) begin
          m_user   <= {m_user[11:0], digitIn};
          m_digits <= m_digits + 1;
          if (m_digits == 3) m_mode <= 3;
        end
        3: begin
          if (correct) m_score <= (m_score >= 255) ? 255 : m_score + 1;
          else         m_lives <= m_lives - 1;
          m_mode <= 4; m_left <= 4;
        end
        4: if (tick) begin
          if (m_left == 1) begin
            if (m_lives == 0) m_mode <= 5;
            else begin m_mode <= 1; m_left <= 6; m_nr <= 1'b1; end
          end else m_left <= m_left - 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("newRound",     newRound,     m_nr);
    chk("displayPhase", displayPhase, m_mode == 1);
    chk("inputReady",   inputReady,   m_mode == 4);
    chk("gameOver",     gameOver,     m_mode == 5);
    chk("userInt",      userInt,      m_user);
    chk("digitIdx",     digitIdx,     m_digits % 4);
    chk("score",        score,        m_score);
    chk("lives",        lives,        m_lives);
  end

  task automatic cyc(input bit t, input bit s, input bit e, input logic [3:0] d);
    tick = t; btnStart = s; btnEnter = e; digitIn = d;
    @(negedge clk);
    tick = 1'b0; btnStart = 1'b0; btnEnter = 1'b0;
  endtask

  // Starts with the DUT in SHOW; ends one edge after the last RESULT tick.
  task automatic play_round(input bit c, input bit fast, input logic [15:0] val);
    correct = c;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 4'h0);
      if (!fast) cyc(1'b0, 1'b0, 1'b0, 4'h0);
    end
    for (int i = 0; i < 4; i++) cyc(fast, 1'b0, 1'b1, val[15-4*i -: 4]);
    cyc(fast, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_lives", lives, 2'd3);
    chk("rst_score", score, 8'd0);
    rst = 1'b0;
    @(negedge clk);

    // start, SHOW lasts exactly six ticks; btnEnter during SHOW is ignored
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("t1_newRound", newRound, 1'b1);
    chk("t1_disp_on", displayPhase, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    chk("t1_newRound_once", newRound, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 4'h5);
      cyc(1'b0, 1'b0, 1'b0, 4'h0);
    end
    chk("t1_disp_after5", displayPhase, 1'b1);
    chk("t4_user_show", userInt, 16'h0);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("t1_disp_after6", displayPhase, 1'b0);

    // passing round A371, with btnStart in ENTRY ignored
    correct = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 4'hA);
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("t4_start_in_entry_disp", displayPhase, 1'b0);
    chk("t4_start_in_entry_idx", digitIdx, 2'd1);
    cyc(1'b0, 1'b1, 1'b1, 4'h3);
    chk("t2_user2", userInt, 16'h00A3);
    cyc(1'b0, 1'b0, 1'b1, 4'h7);
    cyc(1'b0, 1'b0, 1'b1, 4'h1);
    chk("t2_userInt", userInt, 16'hA371);
    chk("t2_check_not_ready", inputReady, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    chk("t2_ready", inputReady, 1'b1);
    chk("t2_score", score, 8'd1);
    chk("t2_lives", lives, 2'd3);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 4'hF);
    chk("t4_ready_held", inputReady, 1'b1);
    chk("t4_user_held", userInt, 16'hA371);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("t2_next_disp", displayPhase, 1'b1);
    chk("t2_next_newRound", newRound, 1'b1);

    // asynchronous reset in ENTRY after two digits
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 1'b1, 4'hA);
    cyc(1'b0, 1'b0, 1'b1, 4'h3);
    chk("t5_pre_user", userInt, 16'h00A3);
    #2 rst = 1'b1;
    #1;
    chk("t5_user", userInt, 16'h0);
    chk("t5_idx", digitIdx, 2'd0);
    chk("t5_score", score, 8'd0);
    chk("t5_lives", lives, 2'd3);
    chk("t5_disp", displayPhase, 1'b0);
    chk("t5_ready", inputReady, 1'b0);
    chk("t5_over", gameOver, 1'b0);
    chk("t5_nr", newRound, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // three failing rounds to game over
    cyc(1'b0, 1'b1, 1'b0, 4'h0);
    chk("t3_start_nr", newRound, 1'b1);
    play_round(1'b0, 1'b0, 16'h1234);
    chk("t3_lives2", lives, 2'd2);
    play_round(1'b0, 1'b0, 16'h5678);
    chk("t3_lives1", lives, 2'd1);
    play_round(1'b0, 1'b0, 16'h9ABC);
    chk("t3_over", gameOver, 1'b1);
    chk("t3_lives0", lives, 2'd0);
    chk("t3_score0", score, 8'd0);
    cyc(1'b0, 1'b0, 1'b1, 4'h1);
    chk("t3_over_held", gameOver, 1'b1);

    // restart with a tick on the entry edge; it must not count
    cyc(1'b1, 1'b1, 1'b0, 4'h0);
    chk("t6_restart_over", gameOver, 1'b0);
    chk("t6_restart_disp", displayPhase, 1'b1);
    chk("t6_restart_lives", lives, 2'd3);
    chk("t6_restart_nr", newRound, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("t6_disp_after5", displayPhase, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("t6_disp_after6", displayPhase, 1'b0);
    correct = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 4'(i));
    cyc(1'b0, 1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 4'h0);
    chk("t6_score1", score, 8'd1);

    // saturate score
    for (int r = 0; r < 256; r++) play_round(1'b1, 1'b1, 16'(r * 37));
    chk("t6_score_sat", score, 8'd255);
    play_round(1'b0, 1'b1, 16'hBEEF);
    chk("t6_score_held", score, 8'd255);
    chk("t6_lives2", lives, 2'd2);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
